// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - loader FSM states and fixed TL-UL request fields
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        WRITE,
        WAIT_ACK,
        DONE,
        ERROR
    } state_e;

    localparam int BytesPerWord = 4;

    localparam tlul_pkg::tl_a_op_e TlOpcode = tlul_pkg::PutFullData;
    localparam logic [1:0]         TlSize   = 2'd2;
    localparam logic [3:0]         TlMask   = 4'hF;
    localparam logic [7:0]         TlSource = 8'h00;

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - minimal TL-UL channel types and opcodes used by the loader
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - little-endian 4-byte to 32-bit word shift-in
module byte_word_packer
    import prog_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic [31:0] word_d;

    // Bytes enter at the top and drift down, so the first byte ends in bits 7:0.
    // word_o is the completed word in the same cycle as the final byte.
    assign word_d       = {byte_i, word_q[31:8]};
    assign word_o       = word_d;
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BytesPerWord - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/prog_loader_tlul.sv
// rtl/prog_loader_tlul.sv - UART byte stream to instruction memory boot loader over TL-UL
module prog_loader_tlul
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int          MemAw    = 12,
    parameter int          MaxWords = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_byte_i,
    output logic                rx_ready_o,
    output tlul_pkg::tl_h2d_t   tl_o,
    input  tlul_pkg::tl_d2h_t   tl_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                core_rst_o,
    output logic [MemAw:0]      words_written_o
);

    state_e         state_q;
    logic           a_valid_q;
    logic [31:0]    a_addr_q;
    logic [31:0]    a_data_q;
    logic [MemAw:0] len_q;
    logic [MemAw:0] idx_q;
    logic [MemAw:0] idx_inc;
    logic           byte_acc;
    logic [31:0]    word;
    logic           word_valid;
    logic           unused_tl;

    assign rx_ready_o      = (state_q == LEN) || (state_q == DATA);
    assign byte_acc        = rx_valid_i && rx_ready_o;
    assign busy_o          = (state_q != DONE) && (state_q != ERROR);
    assign done_o          = (state_q == DONE);
    assign err_o           = (state_q == ERROR);
    assign core_rst_o      = (state_q != DONE);
    assign words_written_o = idx_q;
    assign idx_inc         = idx_q + (MemAw + 1)'(1);
    assign unused_tl       = ^tl_i;

    // One packer serves both the length field and the data words; its count wraps every 4 bytes.
    byte_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_acc),
        .byte_i       (rx_byte_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = TlOpcode;
        tl_o.a_size    = TlSize;
        tl_o.a_source  = TlSource;
        tl_o.a_mask    = TlMask;
        tl_o.a_address = a_addr_q;
        tl_o.a_data    = a_data_q;
        tl_o.d_ready   = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= LEN;
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                LEN: if (word_valid) begin
                    len_q   <= word[MemAw:0];
                    state_q <= (word == '0 || word > 32'(MaxWords)) ? ERROR : DATA;
                end
                DATA: if (word_valid) begin
                    a_valid_q <= 1'b1;
                    a_addr_q  <= BaseAddr + (32'(idx_q) << 2);
                    a_data_q  <= word;
                    state_q   <= WRITE;
                end
                WRITE: if (tl_i.a_ready) begin
                    a_valid_q <= 1'b0;
                    state_q   <= WAIT_ACK;
                end
                // Responses arriving in other states are accepted by d_ready and dropped.
                WAIT_ACK: if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        state_q <= ERROR;
                    end else begin
                        idx_q   <= idx_inc;
                        state_q <= (idx_inc == len_q) ? DONE : DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_tlul.sv
// tb/tb_prog_loader_tlul.sv - directed self-checking bench for prog_loader_tlul
module tb_prog_loader_tlul;
    import tlul_pkg::*;

    localparam int MemAw    = 12;
    localparam int MaxWords = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_ready_o;
    tl_h2d_t           tl_o;
    tl_d2h_t           tl_i;
    logic              busy_o, done_o, err_o, core_rst_o;
    logic [MemAw:0]    words_written_o;

    logic              a_ready = 1'b1;
    logic              d_valid = 1'b0;
    logic              d_error = 1'b0;

    int                total = 0;
    int                bad = 0;
    int                last_wait = 0;
    int                stall_req = 0;
    int                stall_seen = 0;
    int                drop_idx = -1;
    bit                err_inject = 1'b0;
    bit                ack_pend = 1'b0;
    int                pend_idx = 0;
    int                tx_count = 0;
    logic [31:0]       tx_addr [8];
    logic [31:0]       tx_data [8];

    always #5 clk = ~clk;

    prog_loader_tlul #(
        .BaseAddr (32'h0000_0000),
        .MemAw    (MemAw),
        .MaxWords (MaxWords)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rx_valid_i      (rx_valid),
        .rx_byte_i       (rx_byte),
        .rx_ready_o      (rx_ready_o),
        .tl_o            (tl_o),
        .tl_i            (tl_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .core_rst_o      (core_rst_o),
        .words_written_o (words_written_o)
    );

    always_comb begin
        tl_i          = '0;
        tl_i.a_ready  = a_ready;
        tl_i.d_valid  = d_valid;
        tl_i.d_error  = d_error;
        tl_i.d_opcode = AccessAck;
    end

    // Memory model: optional A stall, D response one cycle after the A handshake.
    always @(negedge clk) begin
        if (rst) begin
            ack_pend   = 1'b0;
            d_valid    = 1'b0;
            d_error    = 1'b0;
            a_ready    = 1'b1;
            tx_count   = 0;
            stall_seen = 0;
        end else begin
            d_valid = 1'b0;
            d_error = 1'b0;
            if (ack_pend && pend_idx != drop_idx) begin
                d_valid = 1'b1;
                d_error = err_inject;
            end
            ack_pend = 1'b0;
            if (tl_o.a_valid && stall_seen < stall_req) begin
                a_ready = 1'b0;
                stall_seen++;
            end else begin
                a_ready = 1'b1;
            end
            if (tl_o.a_valid && a_ready) begin
                if (tx_count < 8) begin
                    tx_addr[tx_count] = tl_o.a_address;
                    tx_data[tx_count] = tl_o.a_data;
                end
                pend_idx = tx_count;
                tx_count++;
                ack_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_byte  = b;
        while (!rx_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 100) chk("rx_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gapped);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gapped) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_end();
        int n = 0;
        rx_valid = 1'b0;
        while (!done_o && !err_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("end_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_rx_ready", 32'(rx_ready_o), 32'd1);
        chk("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_core_rst", 32'(core_rst_o), 32'd1);
        chk("rst_words", 32'(words_written_o), 32'd0);
        chk("rst_d_ready", 32'(tl_o.d_ready), 32'd1);

        // normal two-word load
        send_word(32'd2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        chk("n_a_valid_lat", 32'(tl_o.a_valid), 32'd1);
        chk("n_a_addr0", tl_o.a_address, 32'h0);
        chk("n_a_data0", tl_o.a_data, 32'h1234_5678);
        chk("n_a_opcode", 32'(tl_o.a_opcode), 32'(PutFullData));
        chk("n_a_size", 32'(tl_o.a_size), 32'd2);
        chk("n_a_mask", 32'(tl_o.a_mask), 32'hF);
        chk("n_a_source", 32'(tl_o.a_source), 32'd0);
        send_byte(8'hEF);
        chk("n_next_byte_wait", 32'(last_wait), 32'd2);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        wait_end();
        chk("n_done", 32'(done_o), 32'd1);
        chk("n_core_rst", 32'(core_rst_o), 32'd0);
        chk("n_busy", 32'(busy_o), 32'd0);
        chk("n_words", 32'(words_written_o), 32'd2);
        chk("n_rx_ready", 32'(rx_ready_o), 32'd0);
        chk("n_tx_count", 32'(tx_count), 32'd2);
        chk("n_tx_addr1", tx_addr[1], 32'h4);
        chk("n_tx_data1", tx_data[1], 32'hDEAD_BEEF);

        // A-channel backpressure
        do_reset();
        stall_req = 5;
        send_word(32'd1, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_a_valid", 32'(tl_o.a_valid), 32'd1);
            chk("bp_a_addr", tl_o.a_address, 32'h0);
            chk("bp_a_data", tl_o.a_data, 32'hCAFE_F00D);
            chk("bp_rx_ready", 32'(rx_ready_o), 32'd0);
            @(negedge clk);
        end
        wait_end();
        chk("bp_tx_count", 32'(tx_count), 32'd1);
        chk("bp_done", 32'(done_o), 32'd1);
        stall_req = 0;

        // illegal lengths
        do_reset();
        send_word(32'd0, 1'b0);
        chk("l0_err", 32'(err_o), 32'd1);
        chk("l0_core_rst", 32'(core_rst_o), 32'd1);
        chk("l0_rx_ready", 32'(rx_ready_o), 32'd0);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("l0_tx_count", 32'(tx_count), 32'd0);
        chk("l0_busy", 32'(busy_o), 32'd0);
        do_reset();
        send_word(32'(MaxWords + 1), 1'b0);
        chk("lmax1_err", 32'(err_o), 32'd1);
        chk("lmax1_core_rst", 32'(core_rst_o), 32'd1);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("lmax1_tx_count", 32'(tx_count), 32'd0);
        do_reset();
        send_word(32'(MaxWords), 1'b0);
        chk("lmax_err", 32'(err_o), 32'd0);
        chk("lmax_rx_ready", 32'(rx_ready_o), 32'd1);

        // D-channel error on first ack
        do_reset();
        err_inject = 1'b1;
        send_word(32'd2, 1'b0);
        send_word(32'h1111_1111, 1'b0);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("de_err", 32'(err_o), 32'd1);
        chk("de_words", 32'(words_written_o), 32'd0);
        chk("de_core_rst", 32'(core_rst_o), 32'd1);
        rx_valid = 1'b1;
        rx_byte  = 8'h22;
        repeat (4) begin
            chk("de_rx_ready", 32'(rx_ready_o), 32'd0);
            @(negedge clk);
        end
        chk("de_tx_count", 32'(tx_count), 32'd1);
        err_inject = 1'b0;

        // reset while waiting for the ack of word 1
        do_reset();
        drop_idx = 1;
        send_word(32'd2, 1'b0);
        send_word(32'hAAAA_0000, 1'b0);
        send_word(32'hBBBB_1111, 1'b0);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rm_words_pre", 32'(words_written_o), 32'd1);
        chk("rm_busy_pre", 32'(busy_o), 32'd1);
        do_reset();
        drop_idx = -1;
        chk("rm_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("rm_rx_ready", 32'(rx_ready_o), 32'd1);
        chk("rm_words", 32'(words_written_o), 32'd0);
        chk("rm_core_rst", 32'(core_rst_o), 32'd1);
        send_word(32'd1, 1'b0);
        send_word(32'h0BAD_F00D, 1'b0);
        wait_end();
        chk("rm_tx_count", 32'(tx_count), 32'd1);
        chk("rm_tx_addr0", tx_addr[0], 32'h0);
        chk("rm_tx_data0", tx_data[0], 32'h0BAD_F00D);
        chk("rm_done", 32'(done_o), 32'd1);

        // gapped input, then bytes after DONE
        do_reset();
        send_word(32'd2, 1'b1);
        send_word(32'h4433_2211, 1'b1);
        send_word(32'h8877_6655, 1'b1);
        wait_end();
        chk("g_words", 32'(words_written_o), 32'd2);
        chk("g_tx_data0", tx_data[0], 32'h4433_2211);
        chk("g_tx_addr1", tx_addr[1], 32'h4);
        chk("g_tx_data1", tx_data[1], 32'h8877_6655);
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        repeat (4) begin
            chk("g_post_rx_ready", 32'(rx_ready_o), 32'd0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("g_post_done", 32'(done_o), 32'd1);
        chk("g_post_tx_count", 32'(tx_count), 32'd2);
        chk("g_post_words", 32'(words_written_o), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
